uart_tx_serializer: RTL and testbench

UART transmit stage that sits directly downstream of the TX FIFO. It pops bytes from the FIFO through its rd_en/empty/data_out interface and serializes each byte onto the tx line as an 8N1 frame (start bit, data bits LSB first, stop bits). One frame is in flight at a time. Back-to-back bytes are fetched automatically while the FIFO is non-empty and the transmitter is enabled.

---
 rtl/uart_tx_serializer.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter fed from a registered-output TX FIFO (pop, then capture on the next cycle).
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [2:0]           state_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MAX  = CW'(DATA_BITS - 1);
  localparam logic          STOP_MAX = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  // Valid/ready contract with the FIFO: fifo_rd_en is a one-cycle pop that is
  // only raised in IDLE when !fifo_empty; fifo_data is taken the next cycle.
  state_t                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [CW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   baud_end;

  assign baud_end = (baud_q == BAUD_MAX);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    par_d      = par_q;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (!reset && tx_en && !fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
        par_d   = (^fifo_data) ^ PARITY_ODD;
`endif
        baud_d  = '0;
        bit_d   = '0;
        stop_d  = 1'b0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_MAX) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_q == STOP_MAX) begin
            tx_done = 1'b1;
            stop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line lines up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

`ifndef UART_TX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD ^ par_q;
`endif

  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4 and a registered-output FIFO model.
module tb_uart_tx_serializer;

  localparam int CPB = 4;
  localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] dut_state;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .STOP_BITS(1),
    .PARITY_ODD(PODD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_en(tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done),
    .state_o(dut_state)
  );

  // FIFO model: registered read data, valid the cycle after the pop
  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int dbl_cnt = 0;
  logic rd_prev = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    rd_prev <= fifo_rd_en;
    if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
    if (fifo_rd_en && rd_prev) dbl_cnt <= dbl_cnt + 1;
    if (fifo_rd_en && rd_ptr != wr_ptr) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic wait_pop(input string tag, input bit immediate);
    int n;
    n = 0;
    #1;
    if (immediate) begin
      check({tag, "_pop_now"}, 32'(fifo_rd_en), 32'd1);
    end else begin
      while (fifo_rd_en !== 1'b1 && n < 60) begin
        @(negedge clk);
        #1;
        n++;
      end
      check({tag, "_pop_seen"}, 32'(fifo_rd_en), 32'd1);
    end
  endtask

  // Called at the pop cycle; follows FETCH, the whole frame and the first IDLE cycle.
  task automatic frame_body(input logic [7:0] b, input string tag, input bit drop_en);
    logic bits [0:NBITS-1];
    logic [7:0] got;
    int tx_err, done_cnt, done_at, busy_err;
    tx_err = 0; done_cnt = 0; done_at = -1; busy_err = 0; got = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = (^b) ^ PODD;
    bits[10] = 1'b1;
`else
    bits[9]  = 1'b1;
`endif
    @(negedge clk);
    check({tag, "_fetch_rd"}, 32'(fifo_rd_en), 32'd0);
    check({tag, "_fetch_busy"}, 32'(busy), 32'd1);
    check({tag, "_fetch_tx"}, 32'(tx), 32'd1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (drop_en && k == 20) tx_en = 1'b0;
      if (tx !== bits[k / CPB]) tx_err++;
      if (tx_done) begin done_cnt++; done_at = k; end
      if (!busy) busy_err++;
      if (k / CPB >= 1 && k / CPB <= 8 && k % CPB == CPB / 2) got[k / CPB - 1] = tx;
    end
    check({tag, "_tx_errs"}, 32'(tx_err), 32'd0);
    check({tag, "_byte"}, 32'(got), 32'(b));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'(FRAME - 1));
    check({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
    @(negedge clk);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_tx"}, 32'(tx), 32'd1);
    check({tag, "_end_done"}, 32'(tx_done), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit immediate, input string tag);
    wait_pop(tag, immediate);
    frame_body(b, tag, 1'b0);
  endtask

  task automatic idle_watch(input int cycles, input string tag);
    int p0, tx_err;
    p0 = pop_cnt;
    tx_err = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) tx_err++;
    end
    check({tag, "_no_pop"}, 32'(pop_cnt - p0), 32'd0);
    check({tag, "_idle_tx"}, 32'(tx_err), 32'd0);
  endtask

  initial begin
    int p0, rd_hi;
    reset = 1'b1;
    tx_en = 1'b1;
    fifo_data = '0;
    push(8'hA5);

    // reset held two cycles with the FIFO non-empty
    rd_hi = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      if (fifo_rd_en) rd_hi++;
    end
    check("rst_rd_en", 32'(rd_hi), 32'd0);
    check("rst_pops", 32'(pop_cnt), 32'd0);
    reset = 1'b0;

    // single byte 0xA5: bits 0,1,0,1,0,0,1,0,1,1
    send_frame(8'hA5, 1'b0, "a5");

    // tx_en low with data waiting
    tx_en = 1'b0;
    push(8'h00);
    push(8'hFF);
    idle_watch(50, "gate");

    // back-to-back 0x00 then 0xFF: second pop lands right after the stop bit
    p0 = pop_cnt;
    tx_en = 1'b1;
    send_frame(8'h00, 1'b0, "b2b0");
    send_frame(8'hFF, 1'b1, "b2b1");
    check("b2b_pops", 32'(pop_cnt - p0), 32'd2);

    // tx_en dropped mid-frame
    push(8'h5A);
    push(8'h96);
    wait_pop("drop", 1'b0);
    frame_body(8'h5A, "drop", 1'b1);
    idle_watch(20, "drop_after");
    tx_en = 1'b1;
    send_frame(8'h96, 1'b0, "resume");

    // reset during data bit 3 of 0x3C; 0xC3 must follow, 0x3C never completes
    push(8'h3C);
    push(8'hC3);
    wait_pop("rmf", 1'b0);
    repeat (19) @(negedge clk);
    check("rmf_bit3", 32'(tx), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rmf_tx", 32'(tx), 32'd1);
    check("rmf_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    send_frame(8'hC3, 1'b0, "rmf_next");
    idle_watch(10, "final_idle");

    check("total_pops", 32'(pop_cnt), 32'd7);
    check("double_pops", 32'(dbl_cnt), 32'd0);
    check("fifo_drained", 32'(fifo_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
